// File: rtl/q3_core.sv
// q3_core: registered 4-input Boolean function block.
// Produces F(a,b,c,d) = sum of minterms {0,1,2,5,8,9,10} twice. f comes from
// a minimal sum-of-products cone and f1 from a minimal product-of-sums cone.
// The two cones share no gates, so a mismatch between f and f1 points to a
// broken cone. Minterm index is {a,b,c,d} with a as the MSB.
// Both outputs are registered: one cycle of latency, and a synchronous
// active-high reset that forces both outputs to 0.

module q3_core (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic f,
    output logic f1
);

    // Next-state values for the two output registers.
    logic f_d;
    logic f1_d;

    // Output registers.
    logic f_q;
    logic f1_q;

    // Product terms of the SOP cone. They are kept separate from the POS cone.
    logic sop_t0;   // b'c'
    logic sop_t1;   // b'd'
    logic sop_t2;   // a'c'd

    // Sum terms of the POS cone.
    logic pos_s0;   // c' + d'
    logic pos_s1;   // a' + b'
    logic pos_s2;   // b' + d

    // SOP realisation: F = b'c' + b'd' + a'c'd
    always_comb begin
        sop_t0 = ~b & ~c;
        sop_t1 = ~b & ~d;
        sop_t2 = ~a & ~c & d;
        f_d    = sop_t0 | sop_t1 | sop_t2;
    end

    // POS realisation: F = (c'+d')(a'+b')(b'+d)
    always_comb begin
        pos_s0 = ~c | ~d;
        pos_s1 = ~a | ~b;
        pos_s2 = ~b | d;
        f1_d   = pos_s0 & pos_s1 & pos_s2;
    end

    // Capture both cones on the rising edge. Reset takes priority over evaluation.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_q  <= 1'b0;
            f1_q <= 1'b0;
        end else begin
            f_q  <= f_d;
            f1_q <= f1_d;
        end
    end

    assign f  = f_q;
    assign f1 = f1_q;

endmodule

// File: tb/tb_q3_core.sv
// Directed and random bench for q3_core.
// Inputs are driven on the falling edge, and outputs are sampled 1 ns after
// the rising edge. The expected values come from a minterm table, not from
// the SOP or POS equations.

module tb_q3_core;

  logic clk;
  logic rst;
  logic a;
  logic b;
  logic c;
  logic d;
  logic f;
  logic f1;

  int total;
  int bad;

  logic [15:0] truth_tbl;
  logic [3:0]  boundary_m[4];
  logic        boundary_e[4];

  q3_core dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .f   (f),
    .f1  (f1)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: F is 1 exactly for m in {0,1,2,5,8,9,10}
  function automatic logic ref_f(input logic [3:0] m);
    logic [15:0] tbl;
    tbl = 16'h0727;
    return tbl[m];
  endfunction

  // scoreboard check
  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%b expected=%b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // driver: set inputs on the falling edge, then wait for the rising edge and settle
  task automatic step(input logic r, input logic [3:0] m);
    @(negedge clk);
    rst = r;
    {a, b, c, d} = m;
    @(posedge clk);
    #1;
  endtask

  task automatic check_both(input string tag, input logic exp);
    check({tag, ".f"},  f,  exp);
    check({tag, ".f1"}, f1, exp);
  endtask

  initial begin
    logic [3:0] m;
    logic       r;
    logic       exp;

    total = 0;
    bad = 0;
    rst = 1'b1;
    {a, b, c, d} = 4'b0000;

    // The minterm table must be independent of the SOP and POS equations.
    truth_tbl = 16'h0727;
    check("tbl_m0",  truth_tbl[0], 1'b1);
    check("tbl_m3",  truth_tbl[3], 1'b0);

    // reset check
    step(1'b1, 4'b0000);
    check_both("rst_edge1", 1'b0);
    step(1'b1, 4'b0000);
    check_both("rst_edge2", 1'b0);
    step(1'b0, 4'b0000);
    check_both("rst_release", 1'b1);

    // exhaustive sweep
    for (int i = 0; i < 16; i++) begin
      m = 4'(i);
      step(1'b0, m);
      check_both($sformatf("sweep_m%0d", i), truth_tbl[m]);
    end

    // mid-run reset at 0101
    step(1'b0, 4'b0101);
    check_both("mid_pre", 1'b1);
    step(1'b1, 4'b0101);
    check_both("mid_rst", 1'b0);
    step(1'b0, 4'b0101);
    check_both("mid_release", 1'b1);

    // between-edge glitch: only the value present at the edge (0000) counts
    step(1'b0, 4'b0100);
    check_both("glitch_pre", 1'b0);
    @(negedge clk);
    {a, b, c, d} = 4'b0000;
    #1 {a, b, c, d} = 4'b1111;
    #1 {a, b, c, d} = 4'b0000;
    @(posedge clk);
    #1;
    check_both("glitch_edge", 1'b1);
    // An input change after the edge must not reach the outputs combinationally.
    {a, b, c, d} = 4'b1111;
    #2;
    check_both("glitch_hold", 1'b1);

    // boundary minterms
    boundary_m[0] = 4'b1010; boundary_e[0] = 1'b1;
    boundary_m[1] = 4'b1011; boundary_e[1] = 1'b0;
    boundary_m[2] = 4'b0101; boundary_e[2] = 1'b1;
    boundary_m[3] = 4'b0100; boundary_e[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, boundary_m[i]);
      check_both($sformatf("bound_%b", boundary_m[i]), boundary_e[i]);
    end

    // random equivalence run with about 5% reset pulses
    for (int i = 0; i < 1000; i++) begin
      m = 4'($urandom_range(0, 15));
      r = ($urandom_range(0, 99) < 5);
      step(r, m);
      exp = r ? 1'b0 : ref_f(m);
      check("rand.f",  f,  exp);
      check("rand.f1", f1, exp);
      check("rand.eq", f,  f1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
